// File: rtl/masked_2d_filter_stream.sv
// Streaming masked 2D order-statistic filter: raster pixels in, one ranked result per
// fully-inside n x n window out, with per-frame runtime kernel size, mask, rank and frame size.
module masked_2d_filter_stream #(
    parameter int DATA_BITS   = 8,
    parameter int MAX_N       = 5,
    parameter int MAX_W       = 64,
    parameter int DIM_BITS    = 16,
    parameter int KERNEL_SIZE = MAX_N * MAX_N,
    parameter int N_BITS      = $clog2(MAX_N + 1),
    parameter int R_BITS      = $clog2(KERNEL_SIZE + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [DIM_BITS-1:0]    h,
    input  logic [DIM_BITS-1:0]    w,
    input  logic [N_BITS-1:0]      n,
    input  logic [KERNEL_SIZE-1:0] mask,
    input  logic [R_BITS-1:0]      rank_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_BITS-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_BITS-1:0]   out_data,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);
    localparam int AW = $clog2(MAX_W);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                 state;
    logic [DIM_BITS-1:0]    cfg_h, cfg_w, row, col, nm1;
    logic [N_BITS-1:0]      cfg_n;
    logic [KERNEL_SIZE-1:0] cfg_mask, full_mask;
    logic [R_BITS-1:0]      cfg_rank, pop;
    logic                   in_done, out_last, legal, accept, last_pix, complete;
    logic [AW-1:0]          ci;
    logic [DATA_BITS-1:0]   win  [MAX_N][MAX_N];
    logic [DATA_BITS-1:0]   nwin [MAX_N][MAX_N];
    logic [DATA_BITS-1:0]   lb   [MAX_N-1][MAX_W];
    logic [DATA_BITS-1:0]   elem [KERNEL_SIZE];
    logic [DATA_BITS-1:0]   rank_res;

    // The kernel is anchored to the bottom-right of the MAX_N window (newest pixel),
    // so the mask is re-based there once at start instead of per pixel.
    always_comb begin
        full_mask = '0;
        pop       = '0;
        for (int nn = 1; nn <= MAX_N; nn += 2) begin
            if (int'(n) == nn) begin
                for (int i = 0; i < nn; i++)
                    for (int j = 0; j < nn; j++)
                        full_mask[(MAX_N-nn+i)*MAX_N + (MAX_N-nn+j)] = mask[i*MAX_N + j];
            end
        end
        for (int k = 0; k < KERNEL_SIZE; k++)
            pop = pop + R_BITS'(full_mask[k]);
        legal = n[0] && (int'(n) <= MAX_N) && (DIM_BITS'(n) <= h) && (DIM_BITS'(n) <= w)
                && (w <= DIM_BITS'(MAX_W)) && (pop != '0) && (rank_sel < pop);
    end

    assign ci       = col[AW-1:0];
    assign nm1      = DIM_BITS'(cfg_n) - DIM_BITS'(1);
    assign complete = (row >= nm1) && (col >= nm1);
    assign last_pix = (row == cfg_h - DIM_BITS'(1)) && (col == cfg_w - DIM_BITS'(1));
    assign busy     = (state == ST_RUN);
    assign in_ready = (state == ST_RUN) && !in_done && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N - 1; c++)
                nwin[r][c] = win[r][c+1];
        for (int r = 0; r < MAX_N - 1; r++)
            nwin[r][MAX_N-1] = lb[MAX_N-2-r][ci];
        nwin[MAX_N-1][MAX_N-1] = in_data;
        for (int r = 0; r < MAX_N; r++)
            for (int c = 0; c < MAX_N; c++)
                elem[r*MAX_N + c] = nwin[r][c];
    end

    // Rank of an element = masked elements strictly smaller, ties broken by position,
    // so every masked element gets a unique rank and exactly one matches cfg_rank.
    always_comb begin
        logic [R_BITS-1:0] cnt;
        cnt      = '0;
        rank_res = '0;
        for (int k = 0; k < KERNEL_SIZE; k++) begin
            cnt = '0;
            for (int m = 0; m < KERNEL_SIZE; m++)
                if (cfg_mask[m] && ((elem[m] < elem[k]) || ((elem[m] == elem[k]) && (m < k))))
                    cnt = cnt + R_BITS'(1);
            if (cfg_mask[k] && (cnt == cfg_rank))
                rank_res = elem[k];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][ci] <= in_data;
            for (int k = 1; k < MAX_N - 1; k++)
                lb[k][ci] <= lb[k-1][ci];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cfg_h     <= '0;
            cfg_w     <= '0;
            cfg_n     <= '0;
            cfg_mask  <= '0;
            cfg_rank  <= '0;
            row       <= '0;
            col       <= '0;
            in_done   <= 1'b0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            for (int r = 0; r < MAX_N; r++)
                for (int c = 0; c < MAX_N; c++)
                    win[r][c] <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (legal) begin
                            cfg_h    <= h;
                            cfg_w    <= w;
                            cfg_n    <= n;
                            cfg_mask <= full_mask;
                            cfg_rank <= rank_sel;
                            row      <= '0;
                            col      <= '0;
                            in_done  <= 1'b0;
                            out_last <= 1'b0;
                            state    <= ST_RUN;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                    if (accept) begin
                        win <= nwin;
                        if (col == cfg_w - DIM_BITS'(1)) begin
                            col <= '0;
                            row <= row + DIM_BITS'(1);
                        end else begin
                            col <= col + DIM_BITS'(1);
                        end
                        if (last_pix)
                            in_done <= 1'b1;
                        if (complete) begin
                            out_valid <= 1'b1;
                            out_data  <= rank_res;
                            out_last  <= last_pix;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_masked_2d_filter_stream.sv
// Scoreboard bench for masked_2d_filter_stream: directed frames push hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_masked_2d_filter_stream;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] h = '0;
    logic [15:0] w = '0;
    logic [2:0]  n = '0;
    logic [24:0] mask = '0;
    logic [4:0]  rank_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        busy, done, cfg_err;

    masked_2d_filter_stream #(
        .DATA_BITS(8), .MAX_N(5), .MAX_W(64), .DIM_BITS(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .h(h), .w(w), .n(n), .mask(mask),
        .rank_sel(rank_sel), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass = 0;
    int   done_cnt = 0;
    int   exp_done = 0;
    int   sb[$];
    int   pix_q[$];
    bit   stall_mode = 1'b0;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_mode ? ~out_ready : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst) begin
            if (prev_stall) begin
                check("stall_hold_valid", int'(out_valid), 1);
                check("stall_hold_data", int'(out_data), int'(prev_data));
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready_low", int'(in_ready), 0);
                prev_stall = 1'b1;
                prev_data  = out_data;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got %0d, expected no output", out_data);
                end else begin
                    check("out_data", int'(out_data), sb.pop_front());
                end
            end
        end
    end

    task automatic ramp(input int cnt, input bit descending);
        pix_q.delete();
        for (int i = 0; i < cnt; i++) pix_q.push_back(descending ? cnt - 1 - i : i);
    endtask

    task automatic run_frame(input int hh, input int ww, input int nn, input logic [24:0] mk,
                             input int rk, input int feed_n, input bit gap,
                             input bit lat_chk, input bit wait_done);
        int  idx;
        int  budget;
        bit  acc;
        bit  seen;
        @(posedge clk); #1;
        h = 16'(hh); w = 16'(ww); n = 3'(nn); mask = mk; rank_sel = 5'(rk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        // scramble live config; the frame must keep using the latched values
        h = 16'd2; w = 16'd2; n = 3'd1; mask = 25'h1; rank_sel = 5'd0;
        idx = 0;
        budget = 0;
        while (idx < feed_n && budget < 2000) begin
            in_valid = !(gap && (budget % 3 == 1));
            in_data  = 8'(pix_q[idx]);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            budget++;
            if (acc) begin
                if (lat_chk && idx == 9)  check("latency_before", int'(out_valid), 0);
                if (lat_chk && idx == 10) check("latency_first", int'(out_valid), 1);
                idx++;
            end
        end
        in_valid = 1'b0;
        if (idx < feed_n) check("feed_timeout", idx, feed_n);
        if (wait_done) begin
            exp_done++;
            seen = 1'b0;
            for (int k = 0; k < 500 && !seen; k++) begin
                @(negedge clk);
                if (done) seen = 1'b1;
            end
            check("done_seen", int'(seen), 1);
            check("busy_in_done", int'(busy), 0);
            @(negedge clk);
            check("done_pulse_len", int'(done), 0);
            check("done_count", done_cnt, exp_done);
            check("scoreboard_drained", sb.size(), 0);
        end
    endtask

    task automatic cfg_err_case(input int nn, input logic [24:0] mk, input int rk);
        @(posedge clk); #1;
        h = 16'd4; w = 16'd4; n = 3'(nn); mask = mk; rank_sel = 5'(rk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("cfg_err_pulse", int'(cfg_err), 1);
        check("cfg_err_busy", int'(busy), 0);
        check("cfg_err_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        check("cfg_err_one_cycle", int'(cfg_err), 0);
        check("cfg_err_busy_after", int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_data", int'(out_data), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_done", int'(done), 0);
        check("reset_cfg_err", int'(cfg_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 3x3 median over a 4x4 ramp
        ramp(16, 0);
        sb.push_back(5); sb.push_back(6); sb.push_back(9); sb.push_back(10);
        run_frame(4, 4, 3, 25'h1CE7, 4, 16, 0, 1, 1);

        ramp(16, 0);
        sb.push_back(0); sb.push_back(1); sb.push_back(4); sb.push_back(5);
        run_frame(4, 4, 3, 25'h1CE7, 0, 16, 0, 0, 1);

        ramp(16, 0);
        sb.push_back(10); sb.push_back(11); sb.push_back(14); sb.push_back(15);
        run_frame(4, 4, 3, 25'h1CE7, 8, 16, 0, 0, 1);

        // centre-only mask passes interior pixels through
        ramp(16, 0);
        sb.push_back(5); sb.push_back(6); sb.push_back(9); sb.push_back(10);
        run_frame(4, 4, 3, 25'h0000040, 0, 16, 0, 0, 1);

        // all 25 mask bits set (outer ones ignored), gapped input, toggling out_ready
        stall_mode = 1'b1;
        ramp(16, 0);
        sb.push_back(5); sb.push_back(6); sb.push_back(9); sb.push_back(10);
        run_frame(4, 4, 3, 25'h1FFFFFF, 4, 16, 1, 0, 1);
        stall_mode = 1'b0;

        // full 5x5 kernel on a descending 5x5 frame: window holds 0..24
        ramp(25, 1);
        sb.push_back(3);
        run_frame(5, 5, 5, 25'h1FFFFFF, 3, 25, 0, 0, 1);

        cfg_err_case(4, 25'h1CE7, 4);
        cfg_err_case(3, 25'h1CE7, 9);

        // abort mid-frame with reset, then a clean frame
        ramp(16, 0);
        run_frame(4, 4, 3, 25'h1CE7, 4, 7, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_no_done", done_cnt, exp_done);

        ramp(16, 0);
        sb.push_back(5); sb.push_back(6); sb.push_back(9); sb.push_back(10);
        run_frame(4, 4, 3, 25'h1CE7, 4, 16, 0, 1, 1);

        // n=1 is a pass-through
        pix_q.delete();
        pix_q.push_back(3); pix_q.push_back(1); pix_q.push_back(4); pix_q.push_back(1);
        sb.push_back(3); sb.push_back(1); sb.push_back(4); sb.push_back(1);
        run_frame(2, 2, 1, 25'h1, 0, 4, 0, 0, 1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
